// File: rtl/lock_requester.sv
// lock_requester: turns local lock/unlock requests into single-beat commands
// for the lock module, waits for the ACK on locks and retries after a backoff.
module lock_requester #(
   parameter int unsigned RETRY_DELAY  = 16,
   parameter int unsigned LOCK_ID_BITS = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [7:0]              acc_id,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_unlock,
   input  logic [LOCK_ID_BITS-1:0] req_lock_id,
   output logic                    done,
   output logic                    lock_held,
   output logic                    busy,
   output logic [15:0]             retry_count,
   output logic                    ack_err,
   output logic [63:0]             cmd_tdata,
   output logic                    cmd_tvalid,
   input  logic                    cmd_tready,
   output logic [4:0]              cmd_tdest,
   output logic [7:0]              cmd_tid,
   output logic                    cmd_tlast,
   input  logic [63:0]             ack_tdata,
   input  logic                    ack_tvalid,
   output logic                    ack_tready
);
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned DATA_W = 64;
   localparam logic [7:0] CODE_LOCK   = 8'h04;
   localparam logic [7:0] CODE_UNLOCK = 8'h06;
   localparam logic [7:0] ACK_REJECT  = 8'h00;
   localparam logic [7:0] ACK_OK      = 8'h01;
   localparam logic [CNT_W-1:0] BACKOFF_LOAD = CNT_W'(RETRY_DELAY - 1);

   typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, BACKOFF, DONE} state_e;

   state_e              state_q, state_d;
   logic                unlock_q, unlock_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   cmd_tdata_q, cmd_tdata_d;
   logic                lock_held_q, lock_held_d;
   logic [CNT_W-1:0]    retry_q, retry_d;
   logic                ack_err_q, ack_err_d;
   logic                req_ready_q, req_ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                cmd_tvalid_q, cmd_tvalid_d;
   logic                ack_tready_q, ack_tready_d;
   logic [7:0]          ack_code;
   logic                unused_ack_hi;

   // Only the code byte of the ACK matters; the echoed ID is not checked.
   assign ack_code      = ack_tdata[7:0];
   assign unused_ack_hi = ^ack_tdata[63:8];

   always_comb begin
      state_d     = state_q;
      unlock_d    = unlock_q;
      cnt_d       = cnt_q;
      cmd_tdata_d = cmd_tdata_q;
      lock_held_d = lock_held_q;
      retry_d     = retry_q;
      ack_err_d   = ack_err_q;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               unlock_d    = req_unlock;
               cmd_tdata_d = (DATA_W'(req_lock_id) << 8)
                           | DATA_W'(req_unlock ? CODE_UNLOCK : CODE_LOCK);
               state_d     = SEND;
            end
         end
         SEND: begin
            if (cmd_tready) begin
               if (unlock_q) begin
                  lock_held_d = 1'b0;
                  state_d     = DONE;
               end else begin
                  state_d = WAIT_ACK;
               end
            end
         end
         WAIT_ACK: begin
            if (ack_tvalid) begin
               if (ack_code == ACK_OK) begin
                  lock_held_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  // Unknown codes are flagged, then treated as a reject.
                  if (ack_code != ACK_REJECT) ack_err_d = 1'b1;
                  if (retry_q != '1) retry_d = retry_q + CNT_W'(1);
                  cnt_d   = BACKOFF_LOAD;
                  state_d = BACKOFF;
               end
            end
         end
         BACKOFF: begin
            if (cnt_q == '0) state_d = SEND;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they leave the flops aligned with it.
      req_ready_d  = (state_d == IDLE);
      busy_d       = (state_d != IDLE);
      cmd_tvalid_d = (state_d == SEND);
      ack_tready_d = (state_d == WAIT_ACK);
      done_d       = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         unlock_q     <= 1'b0;
         cnt_q        <= '0;
         cmd_tdata_q  <= '0;
         lock_held_q  <= 1'b0;
         retry_q      <= '0;
         ack_err_q    <= 1'b0;
         req_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cmd_tvalid_q <= 1'b0;
         ack_tready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         unlock_q     <= unlock_d;
         cnt_q        <= cnt_d;
         cmd_tdata_q  <= cmd_tdata_d;
         lock_held_q  <= lock_held_d;
         retry_q      <= retry_d;
         ack_err_q    <= ack_err_d;
         req_ready_q  <= req_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         cmd_tvalid_q <= cmd_tvalid_d;
         ack_tready_q <= ack_tready_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign lock_held   = lock_held_q;
   assign retry_count = retry_q;
   assign ack_err     = ack_err_q;
   assign cmd_tdata   = cmd_tdata_q;
   assign cmd_tvalid  = cmd_tvalid_q;
   assign ack_tready  = ack_tready_q;
   assign cmd_tdest   = 5'h15;
   assign cmd_tid     = acc_id;
   assign cmd_tlast   = 1'b1;
endmodule
